// File: rtl/v_pkg.sv
// Shared types for the list-query pipeline and its front-end query scheduler.
package v_pkg;

  typedef logic [7:0]  id_t;
  typedef logic [2:0]  level_t;
  typedef logic [15:0] key_t;
  typedef logic [15:0] volume_t;
  typedef logic [7:0]  listsize_t;

  localparam int RETRY_MAX_DEF   = 3;
  localparam int BACKOFF_CYC_DEF = 4;

  // Counter width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

  localparam int RETRY_W = cnt_w(RETRY_MAX_DEF);
  localparam int BO_W    = cnt_w(BACKOFF_CYC_DEF);

  typedef logic [RETRY_W-1:0] retry_cnt_t;
  typedef logic [BO_W-1:0]    bo_cnt_t;

  typedef enum logic [1:0] {
    QS_IDLE    = 2'd0,
    QS_PEND    = 2'd1,
    QS_INFL    = 2'd2,
    QS_BACKOFF = 2'd3
  } qslot_state_t;

endpackage

// File: rtl/v_rr_arb.sv
// Round-robin arbiter: one-hot grant among requesters, search starts at an
// internal pointer that moves to just past the winner on every grant.
module v_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int W = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  logic [W-1:0] ptr_r;
  logic [W-1:0] ptr_s;
  logic [W-1:0] win_s;
  logic         found_s;

  // Scan requesters starting at the pointer and pick the first one asserted.
  always_comb begin
    found_s = 1'b0;
    win_s   = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (!found_s && req[W'((int'(ptr_r) + k) % N)]) begin
        found_s = 1'b1;
        win_s   = W'((int'(ptr_r) + k) % N);
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      gnt   = ONE_HOT0 << win_s;
      ptr_s = (win_s == W'(N - 1)) ? {W{1'b0}} : win_s + W'(1);
    end else begin
      gnt   = {N{1'b0}};
      ptr_s = ptr_r;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr_r <= {W{1'b0}};
    end else begin
      ptr_r <= ptr_s;
    end
  end

endmodule

// File: rtl/v_query_sched.sv
// Multi-requester scheduler for the list-query pipe: per-slot capture, RR issue,
// error retry with fixed back-off, and zero-latency result routing.
module v_query_sched
  import v_pkg::*;
#(
  parameter int REQ_N       = 4,
  parameter int RETRY_MAX   = RETRY_MAX_DEF,
  parameter int BACKOFF_CYC = BACKOFF_CYC_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [REQ_N-1:0] i_req_vld,
  input  id_t              i_req_prod_id [REQ_N],
  input  level_t           i_req_level   [REQ_N],
  output logic [REQ_N-1:0] o_req_rdy,
  output logic [REQ_N-1:0] o_rsp_vld,
  output key_t             o_rsp_key,
  output volume_t          o_rsp_size,
  output listsize_t        o_rsp_listsize,
  output logic             o_rsp_error,
  output logic             o_lut_vld,
  output id_t              o_lut_prod_id,
  output level_t           o_lut_level,
  input  logic             i_lut_vld_r,
  input  key_t             i_lut_key,
  input  volume_t          i_lut_size,
  input  logic             i_lut_error,
  input  listsize_t        i_lut_listsize,
  output logic             o_idle
);

  localparam int IDX_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;
  localparam retry_cnt_t RETRY_LAST = retry_cnt_t'(RETRY_MAX);
  localparam bo_cnt_t    BO_LOAD    = bo_cnt_t'(BACKOFF_CYC);
  localparam logic [REQ_N-1:0] ONE_HOT0 = {{(REQ_N-1){1'b0}}, 1'b1};

  qslot_state_t state_r [REQ_N];
  qslot_state_t state_s [REQ_N];
  retry_cnt_t   retry_r [REQ_N];
  retry_cnt_t   retry_s [REQ_N];
  bo_cnt_t      bo_r    [REQ_N];
  bo_cnt_t      bo_s    [REQ_N];
  id_t          id_r    [REQ_N];
  id_t          id_s    [REQ_N];
  level_t       level_r [REQ_N];
  level_t       level_s [REQ_N];

  logic             inflight_vld_r;
  logic [IDX_W-1:0] inflight_idx_r;
  logic [REQ_N-1:0] pend_s;
  logic [REQ_N-1:0] gnt_s;
  logic [IDX_W-1:0] gnt_idx_s;
  logic             res_s;
  logic             res_final_s;
  logic             all_idle_s;

  v_rr_arb #(.N(REQ_N)) u_arb (
    .clk    (clk),
    .arst_n (arst_n),
    .req    (pend_s),
    .gnt    (gnt_s)
  );

  // Slot status decode and AND-OR mux of the granted slot onto the query bus.
  always_comb begin
    gnt_idx_s     = {IDX_W{1'b0}};
    o_lut_prod_id = {$bits(id_t){1'b0}};
    o_lut_level   = {$bits(level_t){1'b0}};
    all_idle_s    = 1'b1;
    for (int i = 0; i < REQ_N; i++) begin
      pend_s[i]     = (state_r[i] == QS_PEND);
      o_req_rdy[i]  = (state_r[i] == QS_IDLE);
      all_idle_s    = all_idle_s & o_req_rdy[i];
      gnt_idx_s     = gnt_idx_s | (IDX_W'(i) & {IDX_W{gnt_s[i]}});
      o_lut_prod_id = o_lut_prod_id | (id_r[i] & {$bits(id_t){gnt_s[i]}});
      o_lut_level   = o_lut_level | (level_r[i] & {$bits(level_t){gnt_s[i]}});
    end
    o_lut_vld = |gnt_s;
    o_idle    = all_idle_s & !inflight_vld_r;
  end

  // Result routing: a stray result with nothing in flight is dropped here.
  always_comb begin
    res_s       = i_lut_vld_r & inflight_vld_r;
    res_final_s = res_s & (!i_lut_error | (retry_r[inflight_idx_r] == RETRY_LAST));
    if (res_final_s) begin
      o_rsp_vld = ONE_HOT0 << inflight_idx_r;
    end else begin
      o_rsp_vld = {REQ_N{1'b0}};
    end
    o_rsp_key      = i_lut_key & {$bits(key_t){res_final_s}};
    o_rsp_size     = i_lut_size & {$bits(volume_t){res_final_s}};
    o_rsp_listsize = i_lut_listsize & {$bits(listsize_t){res_final_s}};
    o_rsp_error    = i_lut_error & res_final_s;
  end

  // Per-slot next-state logic.
  always_comb begin
    for (int i = 0; i < REQ_N; i++) begin
      state_s[i] = state_r[i];
      retry_s[i] = retry_r[i];
      bo_s[i]    = bo_r[i];
      id_s[i]    = id_r[i];
      level_s[i] = level_r[i];
      case (state_r[i])
        QS_IDLE: begin
          if (i_req_vld[i]) begin
            state_s[i] = QS_PEND;
            id_s[i]    = i_req_prod_id[i];
            level_s[i] = i_req_level[i];
            retry_s[i] = {RETRY_W{1'b0}};
          end else begin
            state_s[i] = QS_IDLE;
          end
        end
        QS_PEND: begin
          if (gnt_s[i]) begin
            state_s[i] = QS_INFL;
          end else begin
            state_s[i] = QS_PEND;
          end
        end
        QS_INFL: begin
          if (res_s && (inflight_idx_r == IDX_W'(i))) begin
            if (!i_lut_error || (retry_r[i] == RETRY_LAST)) begin
              state_s[i] = QS_IDLE;
            end else begin
              state_s[i] = QS_BACKOFF;
              retry_s[i] = retry_r[i] + retry_cnt_t'(1);
              bo_s[i]    = BO_LOAD;
            end
          end else begin
            state_s[i] = QS_INFL;
          end
        end
        QS_BACKOFF: begin
          if (bo_r[i] <= bo_cnt_t'(1)) begin
            state_s[i] = QS_PEND;
            bo_s[i]    = {BO_W{1'b0}};
          end else begin
            bo_s[i]    = bo_r[i] - bo_cnt_t'(1);
          end
        end
        default: begin
          state_s[i] = QS_IDLE;
        end
      endcase
    end
  end

  // Slot registers; reset drops anything pending or in flight.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < REQ_N; i++) begin
        state_r[i] <= QS_IDLE;
        retry_r[i] <= {RETRY_W{1'b0}};
        bo_r[i]    <= {BO_W{1'b0}};
        id_r[i]    <= {$bits(id_t){1'b0}};
        level_r[i] <= {$bits(level_t){1'b0}};
      end
    end else begin
      for (int i = 0; i < REQ_N; i++) begin
        state_r[i] <= state_s[i];
        retry_r[i] <= retry_s[i];
        bo_r[i]    <= bo_s[i];
        id_r[i]    <= id_s[i];
        level_r[i] <= level_s[i];
      end
    end
  end

  // In-flight marker: the pipe answers exactly one cycle after issue.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      inflight_vld_r <= 1'b0;
      inflight_idx_r <= {IDX_W{1'b0}};
    end else begin
      inflight_vld_r <= o_lut_vld;
      inflight_idx_r <= gnt_idx_s;
    end
  end

endmodule

// File: tb/tb_v_query_sched.sv
// Directed bench for v_query_sched; the bench itself plays the one-cycle query pipe.
module tb_v_query_sched;
  import v_pkg::*;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [3:0] i_req_vld;
  id_t        i_req_prod_id [4];
  level_t     i_req_level   [4];
  logic [3:0] o_req_rdy;
  logic [3:0] o_rsp_vld;
  key_t       o_rsp_key;
  volume_t    o_rsp_size;
  listsize_t  o_rsp_listsize;
  logic       o_rsp_error;
  logic       o_lut_vld;
  id_t        o_lut_prod_id;
  level_t     o_lut_level;
  logic       i_lut_vld_r;
  key_t       i_lut_key;
  volume_t    i_lut_size;
  logic       i_lut_error;
  listsize_t  i_lut_listsize;
  logic       o_idle;

  int errors = 0;
  int checks = 0;
  int err_left [256];

  always #5 clk = ~clk;

  v_query_sched dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .i_req_vld      (i_req_vld),
    .i_req_prod_id  (i_req_prod_id),
    .i_req_level    (i_req_level),
    .o_req_rdy      (o_req_rdy),
    .o_rsp_vld      (o_rsp_vld),
    .o_rsp_key      (o_rsp_key),
    .o_rsp_size     (o_rsp_size),
    .o_rsp_listsize (o_rsp_listsize),
    .o_rsp_error    (o_rsp_error),
    .o_lut_vld      (o_lut_vld),
    .o_lut_prod_id  (o_lut_prod_id),
    .o_lut_level    (o_lut_level),
    .i_lut_vld_r    (i_lut_vld_r),
    .i_lut_key      (i_lut_key),
    .i_lut_size     (i_lut_size),
    .i_lut_error    (i_lut_error),
    .i_lut_listsize (i_lut_listsize),
    .o_idle         (o_idle)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the pipe answers whatever was issued in the previous cycle.
  task automatic tick();
    logic iss;
    id_t  iss_id;
    #1;
    iss    = o_lut_vld;
    iss_id = o_lut_prod_id;
    @(posedge clk);
    #2;
    i_req_vld      = 4'b0000;
    i_lut_vld_r    = iss;
    i_lut_key      = iss ? {8'h00, iss_id ^ 8'hAE} : 16'h0000;
    i_lut_size     = iss ? {8'h00, iss_id} : 16'h0000;
    i_lut_listsize = iss ? iss_id + 8'd1 : 8'h00;
    i_lut_error    = iss && (err_left[iss_id] > 0);
    if (iss && (err_left[iss_id] > 0)) err_left[iss_id]--;
    #1;
  endtask

  initial begin
    int  iss_cnt;
    int  cyc;
    bit  done;
    logic err_at_rsp;

    arst_n         = 1'b0;
    i_req_vld      = 4'b0000;
    i_lut_vld_r    = 1'b0;
    i_lut_key      = 16'h0000;
    i_lut_size     = 16'h0000;
    i_lut_error    = 1'b0;
    i_lut_listsize = 8'h00;
    for (int i = 0; i < 4; i++) begin
      i_req_prod_id[i] = 8'h00;
      i_req_level[i]   = 3'd0;
    end
    for (int i = 0; i < 256; i++) err_left[i] = 0;

    #3;
    chk("rst_rdy",   32'(o_req_rdy), 32'hF);
    chk("rst_rsp",   32'(o_rsp_vld), 32'h0);
    chk("rst_lut",   32'(o_lut_vld), 32'h0);
    chk("rst_idle",  32'(o_idle),    32'h1);
    chk("rst_key",   32'(o_rsp_key), 32'h0);
    tick();
    tick();
    arst_n = 1'b1;
    tick();

    // Single request, clean result.
    i_req_vld = 4'b0001; i_req_prod_id[0] = 8'd5; i_req_level[0] = 3'd2;
    #1;
    chk("t1_rdy_pre", 32'(o_req_rdy), 32'hF);
    tick();
    chk("t1_lut_vld", 32'(o_lut_vld),     32'h1);
    chk("t1_lut_id",  32'(o_lut_prod_id), 32'h5);
    chk("t1_lut_lvl", 32'(o_lut_level),   32'h2);
    chk("t1_rdy",     32'(o_req_rdy),     32'hE);
    chk("t1_rsp_pre", 32'(o_rsp_vld),     32'h0);
    tick();
    chk("t1_rsp",      32'(o_rsp_vld),      32'h1);
    chk("t1_key",      32'(o_rsp_key),      32'hAB);
    chk("t1_err",      32'(o_rsp_error),    32'h0);
    chk("t1_size",     32'(o_rsp_size),     32'h5);
    chk("t1_lsize",    32'(o_rsp_listsize), 32'h6);
    chk("t1_busy",     32'(o_idle),         32'h0);
    tick();
    chk("t1_rsp_post", 32'(o_rsp_vld), 32'h0);
    chk("t1_idle",     32'(o_idle),    32'h1);
    chk("t1_rdy_post", 32'(o_req_rdy), 32'hF);

    // Reset so the pointer starts at 0, then all four at once.
    arst_n = 1'b0;
    #1;
    chk("r2_idle", 32'(o_idle), 32'h1);
    tick();
    arst_n = 1'b1;
    tick();
    i_req_vld = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      i_req_prod_id[i] = 8'h20 + 8'(i);
      i_req_level[i]   = 3'(i);
    end
    #1;
    tick();
    chk("t2_id0", 32'(o_lut_prod_id), 32'h20);
    tick();
    chk("t2_id1",  32'(o_lut_prod_id), 32'h21);
    chk("t2_rsp0", 32'(o_rsp_vld),     32'h1);
    chk("t2_key0", 32'(o_rsp_key),     32'h8E);
    tick();
    chk("t2_id2",  32'(o_lut_prod_id), 32'h22);
    chk("t2_lvl2", 32'(o_lut_level),   32'h2);
    chk("t2_rsp1", 32'(o_rsp_vld),     32'h2);
    tick();
    chk("t2_id3",  32'(o_lut_prod_id), 32'h23);
    chk("t2_rsp2", 32'(o_rsp_vld),     32'h4);
    tick();
    chk("t2_nolut", 32'(o_lut_vld), 32'h0);
    chk("t2_rsp3",  32'(o_rsp_vld), 32'h8);
    chk("t2_key3",  32'(o_rsp_key), 32'h8D);
    tick();
    chk("t2_idle", 32'(o_idle), 32'h1);
    i_req_vld = 4'b1001; i_req_prod_id[0] = 8'h30; i_req_prod_id[3] = 8'h33;
    #1;
    tick();
    chk("t2_wrap0", 32'(o_lut_prod_id), 32'h30);
    tick();
    chk("t2_wrap3", 32'(o_lut_prod_id), 32'h33);
    chk("t2_wrsp0", 32'(o_rsp_vld),     32'h1);
    tick();
    chk("t2_wrsp3", 32'(o_rsp_vld), 32'h8);
    tick();

    // Slot 1: two errors, then success.
    err_left[8'h41] = 2;
    i_req_vld = 4'b0010; i_req_prod_id[1] = 8'h41; i_req_level[1] = 3'd1;
    #1;
    tick();
    chk("t3_iss1", 32'(o_lut_prod_id), 32'h41);
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("t3_err_norsp", 32'(o_rsp_vld), 32'h0);
      for (int b = 0; b < 4; b++) begin
        tick();
        chk("t3_bo_nolut", 32'(o_lut_vld), 32'h0);
      end
      tick();
      chk("t3_reiss_vld", 32'(o_lut_vld),     32'h1);
      chk("t3_reiss_id",  32'(o_lut_prod_id), 32'h41);
    end
    tick();
    chk("t3_rsp", 32'(o_rsp_vld),   32'h2);
    chk("t3_err", 32'(o_rsp_error), 32'h0);
    chk("t3_key", 32'(o_rsp_key),   32'hEF);
    tick();
    chk("t3_idle", 32'(o_idle), 32'h1);

    // Slot 2 always errors: four issues, one final error strobe.
    err_left[8'h52] = 4;
    i_req_vld = 4'b0100; i_req_prod_id[2] = 8'h52; i_req_level[2] = 3'd4;
    #1;
    iss_cnt = 0; cyc = 0; done = 1'b0; err_at_rsp = 1'b0;
    while (!done && cyc < 60) begin
      tick();
      cyc++;
      if (o_lut_vld) iss_cnt++;
      if (o_rsp_vld != 4'b0000) begin
        done = 1'b1;
        err_at_rsp = o_rsp_error;
        chk("t4_rsp_slot", 32'(o_rsp_vld), 32'h4);
      end
    end
    chk("t4_done",   32'(done),       32'h1);
    chk("t4_cycles", 32'(cyc),        32'd20);
    chk("t4_issues", 32'(iss_cnt),    32'd4);
    chk("t4_error",  32'(err_at_rsp), 32'h1);
    tick();
    chk("t4_rdy", 32'(o_req_rdy), 32'hF);

    // Slot 0 backs off while slots 1 and 3 are served.
    err_left[8'h60] = 1;
    i_req_vld = 4'b0001; i_req_prod_id[0] = 8'h60;
    #1;
    tick();
    chk("t5_iss0", 32'(o_lut_prod_id), 32'h60);
    tick();
    chk("t5_err_norsp", 32'(o_rsp_vld), 32'h0);
    i_req_vld = 4'b1010; i_req_prod_id[1] = 8'h61; i_req_prod_id[3] = 8'h63;
    #1;
    tick();
    chk("t5_iss1", 32'(o_lut_prod_id), 32'h61);
    tick();
    chk("t5_iss3", 32'(o_lut_prod_id), 32'h63);
    chk("t5_rsp1", 32'(o_rsp_vld),     32'h2);
    tick();
    chk("t5_gap",  32'(o_lut_vld), 32'h0);
    chk("t5_rsp3", 32'(o_rsp_vld), 32'h8);
    tick();
    chk("t5_gap2", 32'(o_lut_vld), 32'h0);
    tick();
    chk("t5_reiss_vld", 32'(o_lut_vld),     32'h1);
    chk("t5_reiss_id",  32'(o_lut_prod_id), 32'h60);
    tick();
    chk("t5_rsp0", 32'(o_rsp_vld),   32'h1);
    chk("t5_err0", 32'(o_rsp_error), 32'h0);
    chk("t5_key0", 32'(o_rsp_key),   32'hCE);
    tick();

    // Reset while slot 0 is in flight; late result must be ignored.
    i_req_vld = 4'b0001; i_req_prod_id[0] = 8'h70;
    #1;
    tick();
    chk("t6_iss", 32'(o_lut_prod_id), 32'h70);
    tick();
    chk("t6_rsp_pre", 32'(o_rsp_vld), 32'h1);
    arst_n = 1'b0;
    #1;
    chk("t6_rst_rsp",  32'(o_rsp_vld), 32'h0);
    chk("t6_rst_lut",  32'(o_lut_vld), 32'h0);
    chk("t6_rst_rdy",  32'(o_req_rdy), 32'hF);
    chk("t6_rst_idle", 32'(o_idle),    32'h1);
    chk("t6_rst_key",  32'(o_rsp_key), 32'h0);
    tick();
    arst_n = 1'b1;
    i_lut_vld_r = 1'b1;
    i_lut_key   = 16'h1234;
    #1;
    chk("t6_late_rsp",  32'(o_rsp_vld), 32'h0);
    chk("t6_late_idle", 32'(o_idle),    32'h1);
    chk("t6_late_key",  32'(o_rsp_key), 32'h0);
    tick();
    chk("t6_end_idle", 32'(o_idle), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/v_query_sched.md
Name: v_query_sched

Overview:
- Multi-requester scheduler in front of the list-query pipeline: accepts (prod_id, level) queries from REQ_N clients, round-robin arbitrates them onto the single query bus, and routes each 1-cycle-later result back to its originator.
- Erroring queries (busy list or invalid entry; the pipe does not distinguish) are retried after a fixed back-off, up to RETRY_MAX times, before an error is reported.
- Sits between client logic and the query pipeline's lut_* bus.

Parameters:
- REQ_N, 4, number of requesters (>=2).
- RETRY_MAX, 3, retries after first error; 0 disables retry.
- BACKOFF_CYC, 4, idle cycles in BACKOFF before re-arbitration (>=1).

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
i_req_vld  in  REQ_N  per-requester query valid
i_req_prod_id  in  REQ_N x v_pkg::id_t  query product id
i_req_level  in  REQ_N x v_pkg::level_t  query level
o_req_rdy  out  REQ_N  slot can accept (slot IDLE)
o_rsp_vld  out  REQ_N  one-hot result strobe
o_rsp_key  out  v_pkg::key_t  result key
o_rsp_size  out  v_pkg::volume_t  result volume
o_rsp_listsize  out  v_pkg::listsize_t  result list size
o_rsp_error  out  1  final error after retries exhausted
o_lut_vld  out  1  query issue to pipe
o_lut_prod_id  out  v_pkg::id_t  issued id
o_lut_level  out  v_pkg::level_t  issued level
i_lut_vld_r  in  1  pipe result valid (1 cycle after issue)
i_lut_key  in  v_pkg::key_t  pipe key
i_lut_size  in  v_pkg::volume_t  pipe volume
i_lut_error  in  1  pipe error
i_lut_listsize  in  v_pkg::listsize_t  pipe list size
o_idle  out  1  all slots IDLE, nothing in flight

Behaviour:
- Clock clk; reset asynchronous, active-low, arst_n. In reset all slots IDLE, retry/back-off counters 0, in-flight flag 0, RR pointer 0. Outputs in reset: o_req_rdy all-1, o_rsp_vld 0, o_lut_vld 0, o_idle 1, data outputs 0.
- Per-slot FSM, states IDLE, PEND, INFL, BACKOFF:
  - IDLE->PEND when i_req_vld & o_req_rdy. Capture id/level; retry_cnt=0.
  - PEND->INFL when granted.
  - INFL->IDLE on i_lut_vld_r & !i_lut_error, or on error with retry_cnt==RETRY_MAX.
  - INFL->BACKOFF on error with retry_cnt<RETRY_MAX. Set retry_cnt+=1 and bo_cnt=BACKOFF_CYC.
  - BACKOFF: bo_cnt decrements each cycle; ->PEND when bo_cnt==1.
- o_req_rdy[i] = (state[i]==IDLE). This is flop-derived; no combinational path from i_req_vld.
- Arbitration is computed from flopped slot states only:
  - At most one grant per cycle among PEND slots.
  - Round-robin starting at RR pointer; after a grant, pointer = grant+1 mod REQ_N.
  - o_lut_vld = any grant; prod_id and level are muxed from the granted slot.
- In-flight tracking: inflight_vld_r/inflight_idx_r are registered on grant. Issue is pipelined, so a new grant is allowed in the same cycle a prior result returns.
- Response is a zero-added-latency pass-through:
  - o_rsp_vld[inflight_idx_r] = i_lut_vld_r & inflight_vld_r & (final: !error or retries exhausted).
  - Data outputs are wired directly from i_lut_*; o_rsp_error = i_lut_error on a final strobe.
  - Intermediate (retried) errors produce no o_rsp_vld.
- Latency: request accepted cycle T -> issue earliest T+1 -> o_rsp_vld earliest T+2.
- i_lut_vld_r with inflight_vld_r==0 is ignored (assertion in sim).
- A slot completing in cycle T shows o_req_rdy=1 at T+1; a new request is never accepted same-cycle as completion.
- Reset mid-operation: pending/in-flight queries are dropped, and any late i_lut_vld_r after reset release is ignored (inflight_vld_r==0).
- o_idle = all slots IDLE & !inflight_vld_r.

Decomposition:
- v_pkg gains: qslot_state_t enum (IDLE, PEND, INFL, BACKOFF), the retry counter type sized $clog2(RETRY_MAX+1), and the back-off counter type sized $clog2(BACKOFF_CYC+1).
- One sub-module, v_rr_arb: parameter N; inputs req[N] and clk/arst_n; output one-hot gnt[N]; holds the pointer internally, advancing on any grant.

Test Plan:
- Single request: req0 id=5 level=2 at T, pipe returns key=0xAB no error -> o_lut_vld T+1 id5/lvl2; o_rsp_vld=4'b0001 T+2 key 0xAB, error 0.
- All four request same cycle, no errors -> issues on T+1..T+4 in order 0,1,2,3; then a fresh req3+req0 goes to 0 only after pointer wrap (pointer=0 after grant 3).
- req1 pipe errors twice then succeeds (RETRY_MAX=3, BACKOFF_CYC=4) -> no rsp on errors; reissue 5 cycles after each error result; final o_rsp_vld[1] with error 0.
- req2 always errors, RETRY_MAX=3 -> 4 issues total, single o_rsp_vld[2] with o_rsp_error=1, slot IDLE next cycle.
- Back-to-back: req0 in BACKOFF while req1/req3 PEND -> req1, req3 served during back-off; req0 reissued when back-off expires.
- arst_n asserted while slot0 INFL -> outputs at reset values immediately; injected i_lut_vld_r after release produces no o_rsp_vld; o_idle=1.
